// File: rtl/servo_pkg.sv
`default_nettype none
// servo_pkg: shared FSM encoding, bus constants and sweep-step helper for servo_sweep_master.
// Rev 1.0
package servo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EN_WR  = 3'd1,
    ST_ANG_WR = 3'd2,
    ST_DWELL  = 3'd3,
    ST_DIS_WR = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] EN_ON       = 32'h1111_1111;
  localparam logic [31:0] EN_OFF      = 32'h0000_0000;
  localparam logic [7:0]  ANGLE_MAX   = 8'd180;
  localparam logic [31:0] EN_OFFSET   = 32'd4;

  typedef struct packed {
    logic       up;
    logic [7:0] angle;
  } sweep_pos_t;

  // Arithmetic is carried one bit wider (signed on the way down) so a step
  // that overshoots either bound clamps instead of wrapping.
  function automatic sweep_pos_t next_pos(input logic [7:0] angle,
                                          input logic [7:0] step,
                                          input logic [7:0] amin,
                                          input logic [7:0] amax,
                                          input logic       up);
    sweep_pos_t       r;
    logic [8:0]       stp;
    logic [8:0]       sum;
    logic signed [9:0] diff;
    stp  = (step == 8'd0) ? 9'd1 : {1'b0, step};
    sum  = {1'b0, angle} + stp;
    diff = $signed({2'b00, angle}) - $signed({1'b0, stp});
    r.up    = up;
    r.angle = angle;
    if (amin == amax) begin
      r.angle = amin;
    end else if (up) begin
      if (sum >= {1'b0, amax}) begin
        r.angle = amax;
        r.up    = 1'b0;
      end else begin
        r.angle = sum[7:0];
      end
    end else begin
      if (diff <= $signed({2'b00, amin})) begin
        r.angle = amin;
        r.up    = 1'b1;
      end else begin
        r.angle = diff[7:0];
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axil_wr_engine.sv
`default_nettype none
// axil_wr_engine: issues one AXI-Lite write per req pulse and reports the B response.
// Rev 1.0
module axil_wr_engine
  import servo_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        done_o,
  output logic [1:0]  resp_o,
  output logic [31:0] awaddr_o,
  output logic [2:0]  awprot_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  input  logic        bvalid_i,
  output logic        bready_o,
  input  logic [1:0]  bresp_i
);

  logic        act_q;
  logic        awv_q;
  logic        wv_q;
  logic        aw_done_q;
  logic        w_done_q;
  logic        bready_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;

  logic        b_hs;
  logic        accept;
  logic        aw_fin;
  logic        w_fin;

  assign b_hs   = bvalid_i & bready_q;
  // A new request may ride on the B handshake so back-to-back writes lose no cycle.
  assign accept = req_i & (~act_q | b_hs);
  assign aw_fin = aw_done_q | (awv_q & awready_i);
  assign w_fin  = w_done_q | (wv_q & wready_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      act_q     <= 1'b0;
      awv_q     <= 1'b0;
      wv_q      <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bready_q  <= 1'b0;
      addr_q    <= 32'd0;
      data_q    <= 32'd0;
    end else if (accept) begin
      act_q     <= 1'b1;
      awv_q     <= 1'b1;
      wv_q      <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bready_q  <= 1'b0;
      addr_q    <= addr_i;
      data_q    <= data_i;
    end else begin
      if (awv_q && awready_i) begin
        awv_q     <= 1'b0;
        aw_done_q <= 1'b1;
      end
      if (wv_q && wready_i) begin
        wv_q     <= 1'b0;
        w_done_q <= 1'b1;
      end
      if (b_hs) begin
        bready_q <= 1'b0;
        act_q    <= 1'b0;
      end else if (act_q && aw_fin && w_fin) begin
        bready_q <= 1'b1;
      end
    end
  end

  assign done_o    = b_hs;
  assign resp_o    = bresp_i;
  assign awaddr_o  = addr_q;
  assign awprot_o  = 3'b000;
  assign awvalid_o = awv_q;
  assign wdata_o   = data_q;
  assign wstrb_o   = 4'hF;
  assign wvalid_o  = wv_q;
  assign bready_o  = bready_q;

endmodule
`default_nettype wire

// File: rtl/servo_sweep_master.sv
`default_nettype none
// servo_sweep_master: enables a servo, sweeps its angle register between bounds, then disables it.
// Rev 1.0
module servo_sweep_master
  import servo_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned DWELL_W   = 24
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               start,
  input  logic               stop,
  input  logic [7:0]         angle_min,
  input  logic [7:0]         angle_max,
  input  logic [7:0]         step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [31:0]        AWADDR,
  output logic [2:0]         AWPROT,
  output logic               AWVALID,
  input  logic               AWREADY,
  output logic [31:0]        WDATA,
  output logic [3:0]         WSTRB,
  output logic               WVALID,
  input  logic               WREADY,
  input  logic               BVALID,
  output logic               BREADY,
  input  logic [1:0]         BRESP,
  output logic               busy,
  output logic               error,
  output logic [7:0]         cur_angle
);

  state_e             state_q;
  logic [7:0]         min_q;
  logic [7:0]         max_q;
  logic [7:0]         step_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [7:0]         angle_q;
  logic               up_q;
  logic               stop_pend_q;
  logic               issue_q;
  logic               error_q;
  logic [7:0]         cur_angle_q;

  logic               eng_done;
  logic [1:0]         eng_resp;
  logic               eng_req;
  logic [31:0]        req_addr;
  logic [31:0]        req_data;
  logic               cfg_ok;
  logic               resp_ok;
  logic               w_stop;
  logic               w_busy;
  logic               fast_req;
  sweep_pos_t         w_next;

  assign cfg_ok  = (angle_min <= angle_max) && (angle_max <= ANGLE_MAX);
  assign resp_ok = (eng_resp == RESP_OKAY);
  assign w_stop  = stop | stop_pend_q;
  assign w_busy  = (state_q != ST_IDLE) && (state_q != ST_ERROR);
  assign w_next  = next_pos(angle_q, step_q, min_q, max_q, up_q);

  // The next angle write is requested in the cycle the wait ends, so with a
  // zero dwell the new AWVALID follows the B handshake directly.
  assign fast_req = ((state_q == ST_ANG_WR) && eng_done && resp_ok && !w_stop &&
                     (dwell_q == '0)) ||
                    ((state_q == ST_DWELL) && !w_stop && (cnt_q == '0));
  assign eng_req  = issue_q | fast_req;

  always_comb begin
    req_addr = BASE_ADDR + EN_OFFSET;
    req_data = EN_ON;
    if (fast_req) begin
      req_addr = BASE_ADDR;
      req_data = {24'd0, w_next.angle};
    end else begin
      case (state_q)
        ST_ANG_WR: begin
          req_addr = BASE_ADDR;
          req_data = {24'd0, angle_q};
        end
        ST_DIS_WR: req_data = EN_OFF;
        default:   req_data = EN_ON;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= ST_IDLE;
      min_q       <= 8'd0;
      max_q       <= 8'd0;
      step_q      <= 8'd0;
      dwell_q     <= '0;
      cnt_q       <= '0;
      angle_q     <= 8'd0;
      up_q        <= 1'b1;
      stop_pend_q <= 1'b0;
      issue_q     <= 1'b0;
      error_q     <= 1'b0;
      cur_angle_q <= 8'd0;
    end else begin
      issue_q <= 1'b0;
      if (stop && w_busy) begin
        stop_pend_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE, ST_ERROR: begin
          if (start) begin
            if (cfg_ok) begin
              min_q       <= angle_min;
              max_q       <= angle_max;
              step_q      <= step;
              dwell_q     <= dwell;
              error_q     <= 1'b0;
              stop_pend_q <= 1'b0;
              issue_q     <= 1'b1;
              state_q     <= ST_EN_WR;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        ST_EN_WR: begin
          if (eng_done) begin
            if (resp_ok) begin
              angle_q <= min_q;
              up_q    <= 1'b1;
              issue_q <= 1'b1;
              if (w_stop) begin
                stop_pend_q <= 1'b0;
                state_q     <= ST_DIS_WR;
              end else begin
                state_q <= ST_ANG_WR;
              end
            end else begin
              error_q     <= 1'b1;
              stop_pend_q <= 1'b0;
              state_q     <= ST_ERROR;
            end
          end
        end
        ST_ANG_WR: begin
          if (eng_done) begin
            if (resp_ok) begin
              cur_angle_q <= angle_q;
              if (w_stop) begin
                stop_pend_q <= 1'b0;
                issue_q     <= 1'b1;
                state_q     <= ST_DIS_WR;
              end else if (dwell_q == '0) begin
                angle_q <= w_next.angle;
                up_q    <= w_next.up;
              end else begin
                cnt_q   <= dwell_q - DWELL_W'(1);
                state_q <= ST_DWELL;
              end
            end else begin
              error_q     <= 1'b1;
              stop_pend_q <= 1'b0;
              state_q     <= ST_ERROR;
            end
          end
        end
        ST_DWELL: begin
          if (w_stop) begin
            stop_pend_q <= 1'b0;
            issue_q     <= 1'b1;
            state_q     <= ST_DIS_WR;
          end else if (cnt_q == '0) begin
            angle_q <= w_next.angle;
            up_q    <= w_next.up;
            state_q <= ST_ANG_WR;
          end else begin
            cnt_q <= cnt_q - DWELL_W'(1);
          end
        end
        ST_DIS_WR: begin
          if (eng_done) begin
            if (!resp_ok) begin
              error_q <= 1'b1;
            end
            stop_pend_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  axil_wr_engine u_eng (
    .clk_i     (ACLK),
    .rst_i     (ARESET),
    .req_i     (eng_req),
    .addr_i    (req_addr),
    .data_i    (req_data),
    .done_o    (eng_done),
    .resp_o    (eng_resp),
    .awaddr_o  (AWADDR),
    .awprot_o  (AWPROT),
    .awvalid_o (AWVALID),
    .awready_i (AWREADY),
    .wdata_o   (WDATA),
    .wstrb_o   (WSTRB),
    .wvalid_o  (WVALID),
    .wready_i  (WREADY),
    .bvalid_i  (BVALID),
    .bready_o  (BREADY),
    .bresp_i   (BRESP)
  );

  assign busy      = w_busy;
  assign error     = error_q;
  assign cur_angle = cur_angle_q;

endmodule
`default_nettype wire

// File: tb/tb_servo_sweep_master.sv
`default_nettype none
// tb_servo_sweep_master: scoreboard bench with a reactive AXI-Lite slave for servo_sweep_master.
// Rev 1.0
`timescale 1ns/1ps
module tb_servo_sweep_master;
  import servo_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] ENA  = 32'h4000_0004;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  angle_min = 8'd0;
  logic [7:0]  angle_max = 8'd0;
  logic [7:0]  step = 8'd0;
  logic [23:0] dwell = 24'd0;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic        BVALID;
  logic        BREADY;
  logic [1:0]  BRESP;
  logic        busy;
  logic        error;
  logic [7:0]  cur_angle;

  always #5 ACLK = ~ACLK;

  servo_sweep_master dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .stop(stop),
    .angle_min(angle_min), .angle_max(angle_max), .step(step), .dwell(dwell),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .busy(busy), .error(error), .cur_angle(cur_angle)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t sb[$];
  int n_tests = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave behaviour knobs and observation counters.
  int aw_dly = 0, w_dly = 0, b_dly = 0;
  int err_idx = -1;
  int b_total = 0, aw_started = 0, proto_viol = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int cyc = 0, b_cyc = 0, last_gap = 0;
  bit got_aw = 0, got_w = 0, bhs = 0, cur_pend = 0;
  bit prev_awv = 0, l_awv = 0, l_awr = 0, l_wv = 0, l_wr = 0, l_bhs = 0;
  logic [31:0] cap_addr = '0, cap_data = '0, l_awaddr = '0, l_wdata = '0;
  logic [7:0]  cur_exp = '0;

  initial begin
    wr_t e;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    forever begin
      @(posedge ACLK);
      if (ARESET) begin
        got_aw = 0; got_w = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        cur_pend = 0; l_awv = 0; l_wv = 0; l_bhs = 0; bhs = 0;
      end else begin
        if (cur_pend) begin
          check_eq("cur_angle", {24'd0, cur_angle}, {24'd0, cur_exp});
          cur_pend = 0;
        end
        if (l_awv && !l_awr && (AWVALID !== 1'b1 || AWADDR !== l_awaddr)) proto_viol++;
        if (l_wv && !l_wr && (WVALID !== 1'b1 || WDATA !== l_wdata)) proto_viol++;
        if (l_bhs && BREADY) proto_viol++;
        if (BREADY && !(got_aw && got_w)) proto_viol++;
        if ((AWVALID && got_aw) || (WVALID && got_w)) proto_viol++;
        if ((AWVALID && AWPROT !== 3'b000) || (WVALID && WSTRB !== 4'hF)) proto_viol++;
        l_awv = AWVALID; l_awr = AWREADY; l_awaddr = AWADDR;
        l_wv = WVALID; l_wr = WREADY; l_wdata = WDATA;
        bhs = BVALID && BREADY;
        l_bhs = bhs;
        if (AWVALID && AWREADY) begin got_aw = 1; cap_addr = AWADDR; end
        if (WVALID && WREADY) begin got_w = 1; cap_data = WDATA; end
        if (bhs) begin
          if (BRESP == RESP_OKAY && cap_addr == BASE) begin
            cur_pend = 1;
            cur_exp = cap_data[7:0];
          end
          got_aw = 0; got_w = 0; b_cnt = 0; b_total++;
        end
      end
      #1;
      cyc++;
      if (ARESET) begin
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; prev_awv = 0;
      end else begin
        if (bhs) begin
          BVALID = 1'b0;
          b_cyc = cyc;
        end
        if (AWVALID && !prev_awv) begin
          aw_started++;
          last_gap = cyc - b_cyc;
        end
        prev_awv = AWVALID;
        if (AWVALID && !got_aw) begin
          if (aw_cnt >= aw_dly) AWREADY = 1'b1;
          else begin AWREADY = 1'b0; aw_cnt++; end
        end else begin
          AWREADY = 1'b0; aw_cnt = 0;
        end
        if (WVALID && !got_w) begin
          if (w_cnt >= w_dly) WREADY = 1'b1;
          else begin WREADY = 1'b0; w_cnt++; end
        end else begin
          WREADY = 1'b0; w_cnt = 0;
        end
        if (got_aw && got_w && !BVALID) begin
          if (b_cnt >= b_dly) begin
            BVALID = 1'b1;
            BRESP = (b_total == err_idx) ? RESP_SLVERR : RESP_OKAY;
            check_eq("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
              e = sb.pop_front();
              check_eq("wr_addr", cap_addr, e.a);
              check_eq("wr_data", cap_data, e.d);
            end
          end else begin
            b_cnt++;
          end
        end
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    sb.push_back('{a: a, d: d});
  endtask

  task automatic push_angles(input int n, input logic [7:0] v0, input logic [7:0] v1,
                             input logic [7:0] v2, input logic [7:0] v3,
                             input logic [7:0] v4, input logic [7:0] v5,
                             input logic [7:0] v6, input logic [7:0] v7,
                             input logic [7:0] v8);
    logic [7:0] vals [9];
    vals = '{v0, v1, v2, v3, v4, v5, v6, v7, v8};
    for (int i = 0; i < n; i++) push(BASE, {24'd0, vals[i]});
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  task automatic pulse_start(input logic [7:0] mn, input logic [7:0] mx,
                             input logic [7:0] st, input logic [23:0] dw);
    @(negedge ACLK);
    angle_min = mn; angle_max = mx; step = st; dwell = dw; start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge ACLK);
    stop = 1'b0;
  endtask

  task automatic wait_aw(input string tag, input int target);
    int k = 0;
    while (aw_started < target && k < 3000) begin
      @(negedge ACLK);
      k++;
    end
    check_eq(tag, aw_started, target);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    @(negedge ACLK);
    while (busy && k < 3000) begin
      @(negedge ACLK);
      k++;
    end
    check_eq(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int aw0;
    int b0;
    int k;

    // Reset state
    cycles(3);
    check_eq("rst_awvalid", {31'd0, AWVALID}, 32'd0);
    check_eq("rst_wvalid", {31'd0, WVALID}, 32'd0);
    check_eq("rst_bready", {31'd0, BREADY}, 32'd0);
    check_eq("rst_busy_err", {30'd0, busy, error}, 32'd0);
    check_eq("rst_cur_angle", {24'd0, cur_angle}, 32'd0);
    check_eq("rst_awaddr", AWADDR, 32'd0);
    check_eq("rst_wdata", WDATA, 32'd0);
    ARESET = 1'b0;
    cycles(2);

    // Small sweep, dwell 0, stop while the 7th write is in flight
    aw0 = aw_started;
    push(ENA, EN_ON);
    push_angles(6, 10, 11, 12, 11, 10, 11, 0, 0, 0);
    push(ENA, EN_OFF);
    pulse_start(8'd10, 8'd12, 8'd1, 24'd0);
    check_eq("s1_busy", {31'd0, busy}, 32'd1);
    wait_aw("s1_aw7", aw0 + 7);
    check_eq("s1_gap_dwell0", last_gap, 0);
    pulse_stop();
    wait_idle("s1_idle");
    check_eq("s1_cur", {24'd0, cur_angle}, 32'd11);

    // Full range, large step, no 8-bit wrap
    aw0 = aw_started;
    push(ENA, EN_ON);
    push_angles(9, 0, 50, 100, 150, 180, 130, 80, 30, 0);
    push(ENA, EN_OFF);
    pulse_start(8'd0, 8'd180, 8'd50, 24'd0);
    wait_aw("s2_aw10", aw0 + 10);
    pulse_stop();
    wait_idle("s2_idle");

    // AWREADY late, BVALID late, step 0 acts as 1, dwell 3
    aw_dly = 3; w_dly = 0; b_dly = 5;
    aw0 = aw_started;
    push(ENA, EN_ON);
    push_angles(3, 5, 6, 7, 0, 0, 0, 0, 0, 0);
    push(ENA, EN_OFF);
    pulse_start(8'd5, 8'd7, 8'd0, 24'd3);
    wait_aw("s3_aw4", aw0 + 4);
    check_eq("s3_gap_dwell3", last_gap, 3);
    pulse_stop();
    wait_idle("s3_idle");

    // WREADY late, stop during a long dwell
    aw_dly = 0; w_dly = 3; b_dly = 5;
    b0 = b_total;
    push(ENA, EN_ON);
    push_angles(2, 20, 27, 0, 0, 0, 0, 0, 0, 0);
    push(ENA, EN_OFF);
    pulse_start(8'd20, 8'd30, 8'd7, 24'd100);
    k = 0;
    while (b_total < b0 + 3 && k < 3000) begin
      @(negedge ACLK);
      k++;
    end
    check_eq("s4_b3", b_total, b0 + 3);
    cycles(5);
    pulse_stop();
    wait_idle("s4_idle");
    aw_dly = 0; w_dly = 0; b_dly = 0;

    // SLVERR on the third angle write
    aw0 = aw_started;
    err_idx = b_total + 3;
    push(ENA, EN_ON);
    push_angles(3, 10, 12, 14, 0, 0, 0, 0, 0, 0);
    pulse_start(8'd10, 8'd20, 8'd2, 24'd0);
    cycles(40);
    check_eq("s5_error", {31'd0, error}, 32'd1);
    check_eq("s5_busy", {31'd0, busy}, 32'd0);
    check_eq("s5_no_traffic", aw_started, aw0 + 4);
    check_eq("s5_cur", {24'd0, cur_angle}, 32'd12);
    err_idx = -1;
    pulse_start(8'd200, 8'd210, 8'd1, 24'd0);
    cycles(20);
    check_eq("s5_bad_cfg_err", {31'd0, error}, 32'd1);
    check_eq("s5_bad_cfg_quiet", aw_started, aw0 + 4);

    // Recover from ERROR with min == max
    aw0 = aw_started;
    push(ENA, EN_ON);
    push_angles(3, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    push(ENA, EN_OFF);
    pulse_start(8'd1, 8'd1, 8'd3, 24'd0);
    check_eq("s6_err_clr", {31'd0, error}, 32'd0);
    wait_aw("s6_aw4", aw0 + 4);
    pulse_stop();
    wait_idle("s6_idle");

    // Invalid config from IDLE
    aw0 = aw_started;
    pulse_start(8'd50, 8'd40, 8'd1, 24'd0);
    cycles(10);
    check_eq("s7_err", {31'd0, error}, 32'd1);
    check_eq("s7_quiet", aw_started, aw0);

    // Reset while AWVALID is held
    aw_dly = 10;
    aw0 = aw_started;
    pulse_start(8'd30, 8'd40, 8'd5, 24'd0);
    k = 0;
    while (!AWVALID && k < 50) begin
      @(negedge ACLK);
      k++;
    end
    check_eq("s8_awv_pre", {31'd0, AWVALID}, 32'd1);
    ARESET = 1'b1;
    @(posedge ACLK);
    #1;
    check_eq("s8_awvalid", {31'd0, AWVALID}, 32'd0);
    check_eq("s8_wvalid", {31'd0, WVALID}, 32'd0);
    check_eq("s8_busy_bready", {30'd0, busy, BREADY}, 32'd0);
    check_eq("s8_cur", {24'd0, cur_angle}, 32'd0);
    check_eq("s8_addr", AWADDR, 32'd0);
    @(negedge ACLK);
    ARESET = 1'b0;
    aw_dly = 0;
    cycles(20);
    check_eq("s8_no_dis", aw_started, aw0 + 1);

    check_eq("proto_viol", proto_viol, 0);
    check_eq("sb_leftover", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/servo_sweep_master.md
SERVO_SWEEP_MASTER -- requirements
Module: servo_sweep_master

Interface
REQ-001 Parameter BASE_ADDR, default 32'h4000_0000: angle register address; enable register is BASE_ADDR+4.
REQ-002 Parameter DWELL_W, default 24: width of the dwell counter.
REQ-003 ACLK  in  1  single clock, all logic on rising edge.
REQ-004 ARESET  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  one-cycle pulse; latches config and begins a sweep when idle.
REQ-006 stop  in  1  one-cycle pulse; requests an orderly end of the sweep.
REQ-007 angle_min / angle_max / step  in  8 each  sweep bounds and increment, in degrees.
REQ-008 dwell  in  DWELL_W  idle cycles between the B handshake and the next angle write.
REQ-009 AWADDR 32 out, AWPROT 3 out (constant 3'b000), AWVALID out, AWREADY in: AXI-Lite write address channel.
REQ-010 WDATA 32 out, WSTRB 4 out (constant 4'hF), WVALID out, WREADY in: AXI-Lite write data channel.
REQ-011 BVALID in, BREADY out, BRESP 2 in: AXI-Lite write response channel.
REQ-012 busy  out  1  high in any state other than IDLE or ERROR.
REQ-013 error  out  1  sticky fault flag.
REQ-014 cur_angle  out  8  last angle acknowledged with OKAY.

Function
REQ-015 FSM states: IDLE, EN_WR, ANG_WR, DWELL, DIS_WR, ERROR.
REQ-016 IDLE: on start with valid config, go to EN_WR, latch config and clear error; start is ignored outside IDLE and ERROR.
REQ-017 Valid config: angle_min <= angle_max <= 180. If start arrives with an invalid config, set error, stay in the current state, and issue no bus traffic.
REQ-018 EN_WR writes 32'h1111_1111 to BASE_ADDR+4. On OKAY, set angle to angle_min, set direction up, and go to ANG_WR.
REQ-019 ANG_WR writes {24'b0, angle} to BASE_ADDR. On OKAY, update cur_angle and go to DWELL.
REQ-020 DWELL counts dwell cycles; dwell = 0 means zero extra cycles. At expiry, compute the next angle and return to ANG_WR.
REQ-021 Next angle is computed 9 bits wide, with step = 0 treated as 1.
- Up direction: if angle+step >= angle_max, clamp to angle_max and reverse.
- Down direction: if angle-step <= angle_min (signed compare), clamp to angle_min and reverse.
- If angle_min == angle_max, the angle stays constant.
REQ-022 A stop pulse sets a pending flag. The write in flight completes, then the FSM goes to DIS_WR. A stop during DWELL aborts the dwell immediately.
REQ-023 DIS_WR writes 32'h0000_0000 to BASE_ADDR+4, then goes to IDLE regardless of BRESP. A non-OKAY response also sets error.
REQ-024 A BRESP other than 2'b00 in EN_WR or ANG_WR sets error and goes to ERROR with no further traffic. ERROR leaves only on a valid start (to EN_WR).
REQ-025 Write handshake:
- AWVALID and WVALID rise together, at least one cycle after state entry.
- Each VALID holds with stable payload until its READY is sampled high, then drops independently.
- BREADY is high only after both AW and W have completed, and drops the cycle after the BVALID&&BREADY handshake.
REQ-026 AW and W may complete in the same cycle or in either order. At most one write is outstanding.
REQ-027 The earliest next AWVALID is the cycle after the B handshake (dwell = 0). Nothing on the master side adds wait states beyond this.

Reset
REQ-028 Reset values: state IDLE; AWVALID, WVALID, BREADY, busy, error = 0; cur_angle, AWADDR, WDATA = 0; stop-pending = 0.
REQ-029 Reset mid-transaction drops all VALIDs on the next edge, with no completion of the write and no disable write.

Structure
REQ-030 Shared package servo_pkg holds the FSM state enum, RESP_OKAY/RESP_SLVERR, EN_ON = 32'h1111_1111, EN_OFF = 0, ANGLE_MAX = 180, and EN_OFFSET = 4.
REQ-031 Sub-module axil_wr_engine performs one AXI-Lite write per req pulse. It returns done plus the captured BRESP and implements REQ-025/REQ-026; the FSM sequences it.

Verification
REQ-032 Scenario: slave always ready, min=10, max=12, step=1, dwell=0, start. Required: writes EN_ON@+4, then 10, 11, 12, 11, 10, 11...; cur_angle follows each OKAY.
REQ-033 Scenario: min=0, max=180, step=50. Required: angles 0, 50, 100, 150, 180, 130, 80, 30, 0, with no 8-bit wrap.
REQ-034 Scenario: AWREADY delayed 3 cycles, WREADY immediate, then the reverse, then BVALID delayed 5. Required: payload stable, each VALID dropped only after its own READY, single outstanding write.
REQ-035 Scenario: stop during DWELL (dwell=100) and stop during an ANG_WR write. Required: the in-flight write completes, then EN_OFF@+4, then IDLE with busy=0.
REQ-036 Scenario: slave returns SLVERR on the 3rd angle write. Required: error=1, state ERROR, no further AWVALID; a later start with min=200 leaves error=1 with no traffic.
REQ-037 Scenario: ARESET asserted while AWVALID=1. Required: the next cycle shows all outputs at reset values.
